// File: rtl/exc_ctrl_if.sv
// Decoder <-> exception-control bundle.
// Purpose : carries the exception request/cause/ERET inputs and the
//           ack/redirect/flush/MRS outputs of exc_ctrl as one port.
// Latency : n/a (wires only).
// Backpressure: none; ExcAck is a one-cycle pulse, not a handshake.
// Ports (slave = exc_ctrl side):
//   in : Exc, EStatus[3:0], ERet, PC_exc[N-1:0], mrs_sel[1:0]
//   out: ExcAck, redirect, pc_target[N-1:0], flush, in_handler, mrs_data[N-1:0]
interface exc_ctrl_if #(
  parameter int N = 64
);
  logic         Exc;
  logic [3:0]   EStatus;
  logic         ERet;
  logic [N-1:0] PC_exc;
  logic [1:0]   mrs_sel;
  logic         ExcAck;
  logic         redirect;
  logic [N-1:0] pc_target;
  logic         flush;
  logic         in_handler;
  logic [N-1:0] mrs_data;

  // Decoder / fetch side.
  modport master (
    output Exc, EStatus, ERet, PC_exc, mrs_sel,
    input  ExcAck, redirect, pc_target, flush, in_handler, mrs_data
  );

  // Exception control stage.
  modport slave (
    input  Exc, EStatus, ERet, PC_exc, mrs_sel,
    output ExcAck, redirect, pc_target, flush, in_handler, mrs_data
  );
endinterface

// File: rtl/exc_ctrl.sv
// Exception control stage.
// Purpose : latches ELR/ESR on exception entry, redirects fetch to the
//           handler vector and back to ELR on ERET, serves MRS reads.
// Latency : entry ack/redirect one cycle after Exc is sampled in IDLE;
//           ERET redirect is combinational in the same cycle.
// Backpressure: none; requests arriving while in a handler are not queued,
//           they only set the lost-exception sticky bit ESR[8].
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous, active-high
//   bus    - exc_ctrl_if.slave (decoder inputs, fetch/MRS outputs)
// Build option: define EXC_COUNTER_EN to add a saturating 16-bit count of
//   exceptions taken, readable with mrs_sel = 2'b10.
module exc_ctrl #(
  parameter int           N          = 64,
  parameter logic [N-1:0] EXC_VECTOR = {{(N-8){1'b0}}, 8'hD8}
) (
  input  logic          clk,
  input  logic          reset,
  exc_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACK     = 2'd1,
    S_HANDLER = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] elr_q, elr_d;
  logic [3:0]   cause_q, cause_d;
  logic         lost_q, lost_d;

  logic         ack;
  logic         redir;
  logic [N-1:0] target;
  logic         flush_c;
  logic         in_hdl;
  logic [N-1:0] esr;
  logic [N-1:0] cnt_ext;
  logic [N-1:0] mrs;

`ifdef EXC_COUNTER_EN
  logic [15:0]  count_q, count_d;
`endif

  // ---------------------------------------------------------------------
  // State and system registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      elr_q   <= '0;
      cause_q <= '0;
      lost_q  <= 1'b0;
`ifdef EXC_COUNTER_EN
      count_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      elr_q   <= elr_d;
      cause_q <= cause_d;
      lost_q  <= lost_d;
`ifdef EXC_COUNTER_EN
      count_q <= count_d;
`endif
    end
  end

  // ---------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    elr_d   = elr_q;
    cause_d = cause_q;
    lost_d  = lost_q;
`ifdef EXC_COUNTER_EN
    count_d = count_q;
`endif
    ack     = 1'b0;
    redir   = 1'b0;
    target  = '0;
    flush_c = 1'b0;
    in_hdl  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A request beats a coincident ERET here: there is nothing to
        // return from, so ERET is simply dropped.
        if (bus.Exc) begin
          state_d = S_ACK;
          elr_d   = bus.PC_exc;
          cause_d = bus.EStatus;
          lost_d  = 1'b0;
`ifdef EXC_COUNTER_EN
          if (count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
          end
`endif
        end
      end

      S_ACK: begin
        ack     = 1'b1;
        redir   = 1'b1;
        target  = EXC_VECTOR;
        flush_c = 1'b1;
        state_d = S_HANDLER;
      end

      S_HANDLER: begin
        in_hdl = 1'b1;
        if (bus.ERet) begin
          // Return wins over a new request; a level-held IRQ is picked
          // up again from IDLE on the next cycle.
          redir   = 1'b1;
          target  = elr_q;
          flush_c = 1'b1;
          state_d = S_IDLE;
        end else if (bus.Exc) begin
          // No nesting: remember that a request was dropped.
          lost_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // MRS read path (current register contents, before any update)
  // ---------------------------------------------------------------------
  assign esr = {{(N-9){1'b0}}, lost_q, 4'b0000, cause_q};

`ifdef EXC_COUNTER_EN
  assign cnt_ext = {{(N-16){1'b0}}, count_q};
`else
  assign cnt_ext = '0;
`endif

  always_comb begin
    mrs = '0;
    unique case (bus.mrs_sel)
      2'b00:   mrs = elr_q;
      2'b01:   mrs = esr;
      2'b10:   mrs = cnt_ext;
      default: mrs = '0;
    endcase
  end

  assign bus.ExcAck     = ack;
  assign bus.redirect   = redir;
  assign bus.pc_target  = target;
  assign bus.flush      = flush_c;
  assign bus.in_handler = in_hdl;
  assign bus.mrs_data   = mrs;

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: directed stimulus pushes expected redirect events
// into a queue; a negedge monitor pops one whenever the DUT raises
// ExcAck/redirect/flush and compares cycle, kind and target.
module tb_exc_ctrl;

  localparam int          N   = 64;
  localparam logic [63:0] VEC = 64'hD8;
`ifdef EXC_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    int          cyc;
    logic        ack;
    logic [63:0] tgt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t q[$];

  exc_ctrl_if #(.N(N)) bus ();

  exc_ctrl #(.N(N), .EXC_VECTOR(VEC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_mrs(input string name, input logic [1:0] sel, input logic [63:0] exp);
    bus.mrs_sel = sel;
    #1;
    chk(name, bus.mrs_data, exp);
  endtask

  function automatic void push(input int c, input logic a, input logic [63:0] t);
    exp_t e;
    e.cyc = c;
    e.ack = a;
    e.tgt = t;
    q.push_back(e);
  endfunction

  // Monitor: every flagged output must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (bus.ExcAck || bus.redirect || bus.flush) begin
        if (q.size() == 0) begin
          chk("unexpected_event", {61'd0, bus.ExcAck, bus.redirect, bus.flush}, 64'd0);
        end else begin
          e = q.pop_front();
          chk("event_cycle", 64'(cyc), 64'(e.cyc));
          chk("event_ack", {63'd0, bus.ExcAck}, {63'd0, e.ack});
          chk("event_redirect", {63'd0, bus.redirect}, 64'd1);
          chk("event_flush", {63'd0, bus.flush}, 64'd1);
          chk("event_target", bus.pc_target, e.tgt);
        end
      end else begin
        chk("idle_target_zero", bus.pc_target, 64'd0);
        if (q.size() != 0 && q[0].cyc <= cyc) begin
          e = q.pop_front();
          chk("missed_event_cycle", 64'(cyc), 64'(e.cyc + 1));
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    bus.Exc     = 1'b0;
    bus.EStatus = 4'd0;
    bus.ERet    = 1'b0;
    bus.PC_exc  = '0;
    bus.mrs_sel = 2'b00;
    reset       = 1'b1;
    tick();
    tick();
    reset  = 1'b0;
    mon_en = 1'b1;

    // Reset state.
    chk("rst_ack", {63'd0, bus.ExcAck}, 64'd0);
    chk("rst_redirect", {63'd0, bus.redirect}, 64'd0);
    chk("rst_flush", {63'd0, bus.flush}, 64'd0);
    chk("rst_in_handler", {63'd0, bus.in_handler}, 64'd0);
    chk("rst_target", bus.pc_target, 64'd0);
    chk_mrs("rst_elr", 2'b00, 64'd0);
    chk_mrs("rst_esr", 2'b01, 64'd0);
    chk_mrs("rst_cnt", 2'b10, 64'd0);
    chk_mrs("rst_sel3", 2'b11, 64'd0);

    // Exception 1: ext IRQ at 0x40.
    bus.Exc = 1'b1; bus.EStatus = 4'b0001; bus.PC_exc = 64'h40;
    push(cyc + 1, 1'b1, VEC);
    tick();                                    // ACK
    bus.Exc = 1'b0; bus.EStatus = 4'd0;
    chk("ack_in_handler", {63'd0, bus.in_handler}, 64'd0);
    tick();                                    // HANDLER
    chk("h1_in_handler", {63'd0, bus.in_handler}, 64'd1);
    chk_mrs("h1_elr", 2'b00, 64'h40);
    chk_mrs("h1_esr", 2'b01, 64'h1);
    bus.ERet = 1'b1;
    push(cyc, 1'b0, 64'h40);
    tick();                                    // IDLE
    bus.ERet = 1'b0;
    chk("eret1_in_handler", {63'd0, bus.in_handler}, 64'd0);

    // Exception 2 at 0x80, then Exc+ERet together with Exc held.
    bus.Exc = 1'b1; bus.EStatus = 4'b0001; bus.PC_exc = 64'h80;
    push(cyc + 1, 1'b1, VEC);
    tick();                                    // ACK
    bus.Exc = 1'b0;
    tick();                                    // HANDLER
    bus.Exc = 1'b1; bus.ERet = 1'b1; bus.EStatus = 4'b0010; bus.PC_exc = 64'h100;
    push(cyc, 1'b0, 64'h80);
    push(cyc + 2, 1'b1, VEC);
    tick();                                    // IDLE, Exc still held
    bus.ERet = 1'b0;
    chk("both_in_handler", {63'd0, bus.in_handler}, 64'd0);
    chk_mrs("both_esr_nolost", 2'b01, 64'h1);
    tick();                                    // ACK
    bus.Exc = 1'b0;
    tick();                                    // HANDLER
    chk_mrs("h3_elr", 2'b00, 64'h100);
    chk_mrs("h3_esr", 2'b01, 64'h2);
    chk_mrs("h3_count", 2'b10, CNT_EN ? 64'd3 : 64'd0);

    // Request while in handler is lost.
    bus.Exc = 1'b1; bus.EStatus = 4'b0001;
    tick();
    bus.Exc = 1'b0;
    chk("lost_in_handler", {63'd0, bus.in_handler}, 64'd1);
    chk_mrs("lost_esr", 2'b01, 64'h102);
    chk_mrs("lost_elr", 2'b00, 64'h100);
    bus.ERet = 1'b1;
    push(cyc, 1'b0, 64'h100);
    tick();                                    // IDLE
    // ERET in IDLE must not redirect (monitor flags any event).
    tick();
    bus.ERet = 1'b0;
    chk("idle_eret_in_handler", {63'd0, bus.in_handler}, 64'd0);

    // Exc with ERet in IDLE: exception taken; reset lands during ACK.
    bus.Exc = 1'b1; bus.ERet = 1'b1; bus.EStatus = 4'b0001; bus.PC_exc = 64'h200;
    push(cyc + 1, 1'b1, VEC);
    tick();                                    // ACK
    bus.Exc = 1'b0; bus.ERet = 1'b0;
    chk_mrs("ack_count", 2'b10, CNT_EN ? 64'd4 : 64'd0);
    chk_mrs("ack_elr", 2'b00, 64'h200);
    reset = 1'b1;
    tick();                                    // IDLE after reset
    reset = 1'b0;
    chk("post_rst_in_handler", {63'd0, bus.in_handler}, 64'd0);
    chk_mrs("post_rst_elr", 2'b00, 64'd0);
    chk_mrs("post_rst_esr", 2'b01, 64'd0);
    chk_mrs("post_rst_cnt", 2'b10, 64'd0);
    tick();
    chk("post_rst_in_handler2", {63'd0, bus.in_handler}, 64'd0);
    tick();
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception control stage sitting directly downstream of the main decoder: consumes its `Exc`, `EStatus` and `ERet` outputs, latches the exception link and syndrome registers, and returns `ExcAck` to the decoder. It redirects fetch to the fixed exception vector on entry and back to the saved link address on ERET. It also serves the MRS system-register read path.

## Interface
Parameters:
- `N`, 64, datapath / PC width.
- `EXC_VECTOR`, 64'h0000_0000_0000_00D8, handler entry address.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `Exc`  in  1  exception request from decoder (ExtIRQ or NotAnInstr).
- `EStatus`  in  4  exception cause from decoder (0001 ext IRQ, 0010 invalid opcode).
- `ERet`  in  1  ERET instruction in decode this cycle.
- `PC_exc`  in  N  PC of the instruction in decode.
- `mrs_sel`  in  2  MRS source: 00 ELR, 01 ESR, 10 exception count, 11 reads 0.
- `ExcAck`  out  1  one-cycle acknowledge to decoder.
- `redirect`  out  1  fetch must load `pc_target` at next edge.
- `pc_target`  out  N  redirect address.
- `flush`  out  1  squash IF/ID contents this cycle.
- `in_handler`  out  1  high while executing handler code.
- `mrs_data`  out  N  selected system-register value.

## Operation
- States: IDLE, ACK, HANDLER.
- IDLE: `Exc`=1 → at edge ELR←`PC_exc`, ESR←{zeros, `EStatus`}, ESR[8]←0, go ACK. `ERet` in IDLE ignored (no redirect).
- ACK (exactly one cycle): `ExcAck`=1, `redirect`=1, `pc_target`=`EXC_VECTOR`, `flush`=1; `Exc` ignored; next HANDLER unconditionally.
- HANDLER: `in_handler`=1. `ERet`=1 → `redirect`=1, `pc_target`=ELR, `flush`=1 same cycle, next IDLE. `Exc`=1 without `ERet` → no entry (nesting off), ESR[8] (lost-exception sticky) set at edge.
- Simultaneous `Exc` and `ERet` in HANDLER: ERET wins, ESR[8] not set; ext IRQ source must hold request, re-evaluated in IDLE next cycle.
- `Exc` in IDLE with `ERet` also high: exception taken, `ERet` ignored.
- ESR width N; bits [3:0] cause, bit 8 lost flag, others 0.
- `mrs_data` combinational from `mrs_sel`; reads current register value (pre-edge).
- Outputs not listed as active in a state are 0; `pc_target`=0 when `redirect`=0.

## Timing
- Reset values: state IDLE, ELR=0, ESR=0, count=0; `ExcAck`, `redirect`, `flush`, `in_handler`=0, `pc_target`=0, `mrs_data`=0 (ELR selected) .
- `Exc` sampled cycle t (IDLE) → `ExcAck`/`redirect` high cycle t+1 only → fetch at `EXC_VECTOR` from t+2.
- ERET redirect: zero-cycle combinational, state IDLE at t+1; earliest new exception entry `ExcAck` at t+2.
- Back-to-back: IDLE→ACK→HANDLER minimum 2 cycles before ERET can be honoured.
- Reset during ACK or HANDLER: next cycle IDLE, all registers cleared, no `ExcAck` emitted after reset edge.

## Configuration
- `EXC_COUNTER_EN` defined: 16-bit counter increments at each IDLE→ACK edge, saturates at 16'hFFFF, cleared by reset; `mrs_sel`=10 returns it zero-extended to N.
- Not defined: no counter logic; `mrs_sel`=10 returns 0.

## Test plan
- Reset, then `mrs_sel`=00/01/10 → `mrs_data`=0; all control outputs 0.
- IDLE, `Exc`=1, `EStatus`=0001, `PC_exc`=0x40 → next cycle `ExcAck`=1, `redirect`=1, `pc_target`=0xD8, `flush`=1; following cycle `in_handler`=1; ELR reads 0x40, ESR reads 0x1.
- In HANDLER assert `ERet` → same cycle `redirect`=1, `pc_target`=0x40; next cycle IDLE, `in_handler`=0.
- In HANDLER assert `Exc`=1, `EStatus`=0010 for one cycle → no `ExcAck`, ESR reads 0x101; ELR unchanged.
- `Exc` and `ERet` together in HANDLER → return to ELR, ESR[8]=0; hold `Exc` → `ExcAck` two cycles after ERET.
- With `EXC_COUNTER_EN`: take 3 exceptions → `mrs_sel`=10 reads 3; without macro reads 0; reset asserted during ACK → no `ExcAck` next cycle, count 0.
